// File: rtl/lives_counter.sv
// Saturating up/down lives counter with clear, load and a
// post-decrement cooldown window that blocks further decrements.
module lives_counter #(
  parameter int WIDTH    = 4,
  parameter int INIT     = 3,
  parameter int MAX      = 9,
  parameter int COOLDOWN = 8
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             ent,
  input  logic             enp,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             rco,
  output logic             busy
);

  localparam int TW =
    (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INITV = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [TW-1:0]    CDV   = TW'(COOLDOWN);
  localparam logic [TW-1:0]    T1    = TW'(1);
  localparam logic             CDON  = (COOLDOWN != 0);

  logic [TW-1:0] timer;
  logic          count;
  logic          up;
  logic          dn;
  logic          free;

  // The window closes on the edge where the timer expires,
  // so a decrement on that same edge is already accepted.
  always_comb begin
    count = ent & enp;
    free  = (timer <= T1);
    up    = count & inc & ~dec & (Q < MAXV);
    dn    = count & dec & ~inc & free & (Q != '0);
  end

  assign zero = (Q == '0);

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      Q     <= INITV;
      timer <= '0;
      busy  <= 1'b0;
      rco   <= 1'b0;
    end else if (clr) begin
      Q     <= '0;
      timer <= '0;
      busy  <= 1'b0;
      rco   <= 1'b0;
    end else if (ld) begin
      Q     <= (D > MAXV) ? MAXV : D;
      timer <= '0;
      busy  <= 1'b0;
      rco   <= 1'b0;
    end else begin
      rco <= dn & ent & (Q == ONE);
      if (dn) begin
        Q     <= Q - ONE;
        timer <= CDV;
        busy  <= CDON;
      end else begin
        if (up)
          Q <= Q + ONE;
        if (timer != '0)
          timer <= timer - T1;
        busy <= (timer > T1);
      end
    end
  end

endmodule
